// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit-sequencer state encoding.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SEND    = ST_SEND,
        RELEASE = ST_RELEASE
    } state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side byte bus: one valid/data/last lane per requester, ack back.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int N = 4
);
    logic [N-1:0]        req_valid;
    logic [N*BYTE_W-1:0] req_data;
    logic [N-1:0]        req_last;
    logic [N-1:0]        req_ack;

    // Requesters drive bytes and observe the ack.
    modport master (output req_valid, req_data, req_last, input req_ack);
    // The arbiter consumes bytes and returns the ack.
    modport slave  (input req_valid, req_data, req_last, output req_ack);
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan offsets 0..N-1 from ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == (int'(ptr) + k) % N)) begin
                    any = 1'b1;
                    idx = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter among N requesters,
// holding a per-message lock and aborting a send that never sees done.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int               N     = 4,
    parameter int               TMO_W = 16,
    parameter logic [TMO_W-1:0] TMO   = 16'd20000
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arb_if.slave       req,
    output logic [BYTE_W-1:0]  din,
    output logic               send,
    input  logic               done,
    output logic               busy,
    output logic [2:0]         owner,
    output logic               tmo
);

    state_e             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         owner_q, owner_d;
    logic               lock_q, lock_d;
    logic               last_q, last_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  din_q, din_d;
    logic               send_q, send_d;
    logic               tmo_q, tmo_d;
    logic [N-1:0]       ack_q, ack_d;

    logic [N-1:0]       elig;
    logic               pick_any;
    logic [2:0]         pick_idx;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_last;

    function automatic logic [2:0] next_idx(input logic [2:0] v);
        return (v == 3'(N - 1)) ? 3'd0 : v + 3'd1;
    endfunction

    // While a message is locked, only the owner's lane may compete.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = req.req_valid[i] && (!lock_q || (owner_q == 3'(i)));
        end
    end

    rr_pick #(.N(N), .IW(3)) u_pick (
        .req (elig),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Select the winner's byte and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == 3'(i)) begin
                sel_data = req.req_data[i*BYTE_W +: BYTE_W];
                sel_last = req.req_last[i];
            end
        end
    end

    // Next-state and registered-output logic of the grant/send/release sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        send_d  = send_q;
        tmo_d   = 1'b0;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                // A new send is never raised while the UART still reports done.
                if (pick_any && !done) begin
                    din_d   = sel_data;
                    send_d  = 1'b1;
                    owner_d = pick_idx;
                    lock_d  = ~sel_last;
                    last_d  = sel_last;
                    cnt_d   = '0;
                    state_d = SEND;
                    for (int i = 0; i < N; i++) begin
                        ack_d[i] = (pick_idx == 3'(i));
                    end
                end
            end
            SEND: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (done) begin
                    send_d  = 1'b0;
                    state_d = RELEASE;
                    if (last_q) begin
                        ptr_d = next_idx(owner_q);
                    end
                end else if (cnt_q == TMO - TMO_W'(1)) begin
                    // Abort: the message is considered ended, so unlock and rotate.
                    send_d  = 1'b0;
                    tmo_d   = 1'b1;
                    lock_d  = 1'b0;
                    ptr_d   = next_idx(owner_q);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            din_q   <= '0;
            send_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            send_q  <= send_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
        end
    end

    assign din         = din_q;
    assign send        = send_q;
    assign tmo         = tmo_q;
    assign owner       = owner_q;
    assign req.req_ack = ack_q;
    assign busy        = (state_q != IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomised and directed bench for uart_tx_arb with a UART done model,
// a per-requester byte scoreboard and a message-level arbitration model.
module tb_uart_tx_arb;

    localparam int N   = 4;
    localparam int TMO = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } byte_s;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din;
    logic       send;
    logic       done = 1'b0;
    logic       busy;
    logic [2:0] owner;
    logic       tmo;

    uart_tx_arb_if #(.N(N)) rif ();

    uart_tx_arb #(.N(N), .TMO_W(16), .TMO(16'd16)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rif),
        .din   (din),
        .send  (send),
        .done  (done),
        .busy  (busy),
        .owner (owner),
        .tmo   (tmo)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    byte_s msgq[N][$];
    byte_s exp_q[N][$];
    int    lat_q[$];
    int    hold_q[$];
    int    grant_log[$];
    int    exp_log[$];
    int    cur_lat = 0;
    int    tmo_count = 0;
    bit    rand_en = 1'b0;
    bit    flush_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic byte_s mk(input logic [7:0] d, input logic l, input int g);
        byte_s b;
        b.data = d;
        b.last = l;
        b.gap  = g;
        return b;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (msgq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_log(input string name);
        check({name, "_count"}, grant_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++)
            check({name, "_grant"}, grant_log[i], exp_log[i]);
        grant_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < 8000) begin
            @(posedge clk); #4;
            n++;
            if (rif.req_valid == '0 && !busy && !done && !send && all_empty()) quiet++;
            else quiet = 0;
        end
        check({name, "_reaches_idle"}, quiet >= 3, 1);
    endtask

    // Requesters: present queued bytes after their gap, drop or advance on ack.
    initial begin
        byte_s e;
        int    len;
        int    gap_cnt[N];
        for (int i = 0; i < N; i++) gap_cnt[i] = 0;
        rif.req_valid = '0;
        rif.req_data  = '0;
        rif.req_last  = '0;
        forever begin
            @(posedge clk); #2;
            if (flush_req) begin
                rif.req_valid = '0;
                for (int i = 0; i < N; i++) begin
                    msgq[i].delete();
                    exp_q[i].delete();
                    gap_cnt[i] = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (rif.req_valid[i] && rif.req_ack[i]) rif.req_valid[i] = 1'b0;
                    if (!rif.req_valid[i]) begin
                        if (rand_en && msgq[i].size() == 0 && $urandom_range(0, 7) == 0) begin
                            len = $urandom_range(1, 3);
                            for (int b = 0; b < len; b++)
                                msgq[i].push_back(mk(8'($urandom_range(0, 255)), b == len - 1,
                                                     (b == 0) ? $urandom_range(0, 4) : $urandom_range(0, 2)));
                        end
                        if (msgq[i].size() != 0) begin
                            if (gap_cnt[i] < msgq[i][0].gap) begin
                                gap_cnt[i]++;
                            end else begin
                                e = msgq[i].pop_front();
                                gap_cnt[i] = 0;
                                rif.req_data[8*i +: 8] = e.data;
                                rif.req_last[i]        = e.last;
                                rif.req_valid[i]       = 1'b1;
                                exp_q[i].push_back(e);
                            end
                        end
                    end
                end
            end
        end
    end

    // UART model: done rises lat cycles after send rises, stays for hold cycles after send falls.
    initial begin
        int cnt = 0;
        int hcnt = 0;
        int lat = 3;
        int hold = 0;
        int r;
        forever begin
            @(posedge clk); #3;
            if (reset) begin
                done = 1'b0;
                cnt  = 0;
                hcnt = 0;
            end else if (send && !done) begin
                cnt++;
                if (cnt == 1) begin
                    if (lat_q.size() != 0) lat = lat_q.pop_front();
                    else if (rand_en) begin
                        r = $urandom_range(0, 9);
                        lat = (r == 0) ? 20 : (r == 1) ? 15 : $urandom_range(0, 8);
                    end else lat = 3;
                    if (hold_q.size() != 0) hold = hold_q.pop_front();
                    else hold = rand_en ? $urandom_range(0, 3) : 0;
                    cur_lat = lat;
                end
                if (cnt == lat + 1) begin
                    done = 1'b1;
                    hcnt = 0;
                end
            end else if (done && !send) begin
                hcnt++;
                if (hcnt > hold) begin
                    done = 1'b0;
                    cnt  = 0;
                end
            end else if (!send) begin
                cnt = 0;
            end
        end
    end

    // Monitor: message-level arbitration model plus byte scoreboard.
    initial begin
        int    m_ptr = 0;
        bit    m_lock = 1'b0;
        int    m_owner = 0;
        bit    m_last = 1'b0;
        int    hi = 0;
        bit    prev_send = 1'b0;
        bit    prev_done = 1'b0;
        bit    prev_ack = 1'b0;
        int    exp_w;
        int    act_w;
        int    exp_hi;
        bit    exp_t;
        byte_s e;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                m_ptr = 0; m_lock = 1'b0; m_owner = 0; m_last = 1'b0;
                hi = 0; prev_send = 1'b0; prev_done = 1'b0; prev_ack = 1'b0;
            end else begin
                if (rif.req_ack != '0) begin
                    exp_w = -1;
                    if (m_lock) exp_w = m_owner;
                    else begin
                        for (int k = 0; k < N; k++)
                            if (exp_w < 0 && rif.req_valid[(m_ptr + k) % N]) exp_w = (m_ptr + k) % N;
                    end
                    act_w = -1;
                    for (int i = 0; i < N; i++) if (rif.req_ack[i]) act_w = i;
                    grant_log.push_back(act_w);
                    check("ack_only_on_send_rise", {prev_send, send}, 2'b01);
                    check("no_send_while_done", {prev_done, done}, 2'b00);
                    check("ack_not_back_to_back", prev_ack, 0);
                    if (exp_w < 0) begin
                        check("grant_has_eligible_requester", 0, 1);
                    end else begin
                        check("winner_valid", rif.req_valid[exp_w], 1);
                        check("ack_vector", rif.req_ack, 64'd1 << exp_w);
                        check("owner_on_grant", owner, exp_w);
                        if (exp_q[exp_w].size() == 0) begin
                            check("scoreboard_has_byte", 0, 1);
                        end else begin
                            e = exp_q[exp_w].pop_front();
                            check("din_on_grant", din, e.data);
                            m_last  = e.last;
                            m_lock  = !e.last;
                            m_owner = exp_w;
                        end
                    end
                end else if (send && !prev_send) begin
                    check("send_rise_has_ack", 0, 1);
                end
                if (send) hi++;
                if (prev_send && !send) begin
                    exp_t  = (cur_lat + 1 > TMO);
                    exp_hi = exp_t ? TMO : cur_lat + 1;
                    check("send_high_cycles", hi, exp_hi);
                    check("tmo_on_send_fall", tmo, exp_t);
                    if (exp_t) begin
                        m_ptr  = (m_owner + 1) % N;
                        m_lock = 1'b0;
                    end else if (m_last) begin
                        m_ptr = (m_owner + 1) % N;
                    end
                    hi = 0;
                end else if (tmo) begin
                    check("tmo_only_when_send_falls", tmo, 0);
                end
                if (tmo) tmo_count++;
                if (owner >= 3'(N)) check("owner_in_range", owner, 0);
                prev_send = send;
                prev_done = done;
                prev_ack  = (rif.req_ack != '0);
            end
        end
    end

    // Watchdog.
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    // Directed scenarios, random phase, then reset during a locked message.
    initial begin
        int t0;
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        check("reset_send", send, 0);
        check("reset_din", din, 0);
        check("reset_ack", rif.req_ack, 0);
        check("reset_owner", owner, 0);
        check("reset_tmo", tmo, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;

        // Single requester 2: latency 10, done held 5 cycles, then a second byte.
        lat_q  = '{10, 3};
        hold_q = '{5, 0};
        msgq[2].push_back(mk(8'h41, 1'b1, 0));
        msgq[2].push_back(mk(8'h42, 1'b1, 0));
        repeat (2) @(posedge clk);
        #4;
        check("single_ack_k1", rif.req_ack, 4'b0100);
        check("single_send_k1", send, 1);
        check("single_din_k1", din, 8'h41);
        check("single_owner_k1", owner, 2);
        wait_idle("single");
        check("single_busy_after", busy, 0);
        check("single_din_held", din, 8'h42);
        exp_log = '{2, 2};
        check_log("single");

        // Lock: req 0 sends A,B with a gap while req 3 is waiting.
        msgq[0].push_back(mk(8'h41, 1'b0, 0));
        msgq[0].push_back(mk(8'h42, 1'b1, 3));
        msgq[3].push_back(mk(8'h33, 1'b1, 2));
        msgq[3].push_back(mk(8'h34, 1'b1, 0));
        wait_idle("lock");
        exp_log = '{0, 0, 3, 3};
        check_log("lock");

        // Contention: 0 and 1 hold single-byte messages continuously.
        for (int b = 0; b < 3; b++) begin
            msgq[0].push_back(mk(8'(8'h10 + b), 1'b1, 0));
            msgq[1].push_back(mk(8'(8'h20 + b), 1'b1, 0));
        end
        wait_idle("contend");
        exp_log = '{0, 1, 0, 1, 0, 1};
        check_log("contend");

        // Timeout mid-message, then done coinciding with the timeout.
        t0 = tmo_count;
        lat_q = '{100, 15, 3};
        msgq[1].push_back(mk(8'h51, 1'b0, 0));
        msgq[1].push_back(mk(8'h52, 1'b1, 1));
        msgq[0].push_back(mk(8'h61, 1'b1, 3));
        wait_idle("timeout");
        check("timeout_pulses", tmo_count - t0, 1);
        exp_log = '{1, 0, 1};
        check_log("timeout");

        // Random traffic.
        rand_en = 1'b1;
        repeat (3000) @(posedge clk);
        rand_en = 1'b0;
        wait_idle("random");
        check("random_grants_seen", grant_log.size() > 40, 1);
        grant_log.delete();

        // Reset in the middle of a locked message.
        msgq[2].push_back(mk(8'h71, 1'b1, 0));
        wait_idle("pre_reset");
        grant_log.delete();
        lat_q = '{40};
        msgq[3].push_back(mk(8'h81, 1'b0, 0));
        msgq[3].push_back(mk(8'h82, 1'b1, 50));
        n = 0;
        while (grant_log.size() == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("pre_reset_grant_seen", grant_log.size(), 1);
        repeat (5) @(posedge clk);
        #4;
        reset = 1'b1;
        flush_req = 1'b1;
        @(posedge clk);
        #4;
        check("midreset_send", send, 0);
        check("midreset_busy", busy, 0);
        check("midreset_owner", owner, 0);
        check("midreset_ack", rif.req_ack, 0);
        reset = 1'b0;
        flush_req = 1'b0;
        grant_log.delete();
        msgq[1].push_back(mk(8'h91, 1'b1, 0));
        msgq[3].push_back(mk(8'h92, 1'b1, 0));
        wait_idle("post_reset");
        exp_log = '{1, 3};
        check_log("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
